// File: rtl/iob_ram_sp_be_if.sv
// Access bus of the byte-enable single-port RAM.
// Requester drives the access; the RAM returns data, valid and ready.
interface iob_ram_sp_be_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 10
);
    logic                  en;
    logic [DATA_W/8-1:0]   we;
    logic [ADDR_W-1:0]     addr;
    logic [DATA_W-1:0]     din;
    logic [DATA_W-1:0]     dout;
    logic                  dout_valid;
    logic                  ready;

    modport master (
        output en, we, addr, din,
        input  dout, dout_valid, ready
    );

    modport slave (
        input  en, we, addr, din,
        output dout, dout_valid, ready
    );
endinterface

// File: rtl/iob_ram_sp_be.sv
// Single-port synchronous RAM with byte enables, optional output register,
// read-valid strobe, selectable read-during-write and post-reset clear.
module iob_ram_sp_be #(
    parameter int DATA_W      = 32,
    parameter int ADDR_W      = 10,
    parameter int DOUT_REG    = 0,
    parameter int WRITE_FIRST = 0,
    parameter int INIT_CLEAR  = 1
) (
    input logic             clk,
    input logic             rst_n,
    iob_ram_sp_be_if.slave  bus
);
    localparam int NB    = DATA_W / 8;
    localparam int DEPTH = 2 ** ADDR_W;

    typedef enum logic {CLEAR, RUN} state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   cnt_q, cnt_d;
    logic                ready_q;
    logic                clr_we;
    logic                acc;
    logic [DATA_W-1:0]   mem [DEPTH];
    logic [DATA_W-1:0]   old_w, new_w, rdata;
    logic [DATA_W-1:0]   dout_q;
    logic                vld_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            CLEAR: begin
                cnt_d = cnt_q + 1'b1;
                if (&cnt_q) state_d = RUN;
            end
            RUN: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= (INIT_CLEAR != 0) ? CLEAR : RUN;
            cnt_q   <= '0;
            ready_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ready_q <= (state_d == RUN);
        end
    end

    assign clr_we = (state_q == CLEAR) && rst_n;
    assign acc    = bus.en && ready_q && rst_n;
    assign old_w  = mem[bus.addr];

    always_comb begin
        new_w = old_w;
        for (int k = 0; k < NB; k++) begin
            if (bus.we[k]) new_w[8*k +: 8] = bus.din[8*k +: 8];
        end
    end

    assign rdata = (WRITE_FIRST != 0) ? new_w : old_w;

    // Array has no reset: only the clear engine and accepted writes touch it
    always_ff @(posedge clk) begin
        if (clr_we) begin
            mem[cnt_q] <= '0;
        end else if (acc) begin
            for (int k = 0; k < NB; k++) begin
                if (bus.we[k]) mem[bus.addr][8*k +: 8] <= bus.din[8*k +: 8];
            end
        end
    end

    if (DOUT_REG != 0) begin : g_reg
        logic [DATA_W-1:0] pipe_q;
        logic              pvld_q;

        always_ff @(posedge clk) begin
            if (!rst_n) begin
                pipe_q <= '0;
                pvld_q <= 1'b0;
                dout_q <= '0;
                vld_q  <= 1'b0;
            end else begin
                pvld_q <= acc;
                if (acc) pipe_q <= rdata;
                vld_q <= pvld_q;
                if (pvld_q) dout_q <= pipe_q;
            end
        end
    end else begin : g_noreg
        always_ff @(posedge clk) begin
            if (!rst_n) begin
                dout_q <= '0;
                vld_q  <= 1'b0;
            end else begin
                vld_q <= acc;
                if (acc) dout_q <= rdata;
            end
        end
    end

    assign bus.dout       = dout_q;
    assign bus.dout_valid = vld_q;
    assign bus.ready      = ready_q;
endmodule
